// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V controller: state codes,
// the opcodes the main FSM decodes, and the ALUOp codes passed to alu_dec.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S0  = 4'd0,   // FETCH
    S1  = 4'd1,   // DECODE
    S2  = 4'd2,   // MEMADR
    S3  = 4'd3,   // MEMREAD
    S4  = 4'd4,   // MEMWB
    S5  = 4'd5,   // MEMWRITE
    S6  = 4'd6,   // EXECUTER
    S7  = 4'd7,   // ALUWB
    S8  = 4'd8,   // EXECUTEI
    S9  = 4'd9,   // JAL
    S10 = 4'd10   // BEQ
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_main_fsm.sv
// Main FSM of the multicycle RISC-V controller (Moore, 11 states).
//
//   state | meaning
//   S0    | FETCH: read instruction, PC+4; waits for mem_ready
//   S1    | DECODE: read registers, PC+imm precomputed; dispatch on op
//   S2    | MEMADR: rs1 + imm for lw/sw
//   S3    | MEMREAD: data read; waits for mem_ready
//   S4    | MEMWB: load data to register file
//   S5    | MEMWRITE: store; waits for mem_ready
//   S6    | EXECUTER: register-register ALU op
//   S7    | ALUWB: ALU result to register file
//   S8    | EXECUTEI: register-immediate ALU op
//   S9    | JAL: PC <= target, link value formed
//   S10   | BEQ: compare; branch taken is qualified with zero outside
//
// Codes 11..15 are unreachable; if ever seen, outputs go quiet and the
// FSM returns to FETCH.
module mc_main_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       PCUpdate,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Branch,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t state_q;
  state_t state_nxt;
  logic   illegal_nxt;

  // State register and the registered illegal-opcode pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S0;
      illegal_op <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      illegal_op <= illegal_nxt;
    end
  end

  // Next-state and Moore output decode; everything defaults to zero.
  always_comb begin
    state_nxt   = S0;
    illegal_nxt = 1'b0;
    PCUpdate    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    Branch      = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = ALUOP_ADD;
    case (state_q)
      S0: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
        state_nxt = mem_ready ? S1 : S0;
      end
      S1: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_nxt = S2;
          OP_R:         state_nxt = S6;
          OP_I:         state_nxt = S8;
          OP_JAL:       state_nxt = S9;
          OP_BEQ:       state_nxt = S10;
          default: begin
            state_nxt   = S0;
            illegal_nxt = 1'b1;
          end
        endcase
      end
      S2: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        state_nxt = (op == OP_LW) ? S3 : S5;
      end
      S3: begin
        AdrSrc    = 1'b1;
        state_nxt = mem_ready ? S4 : S3;
      end
      S4: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_nxt = S0;
      end
      S5: begin
        AdrSrc    = 1'b1;
        MemWrite  = mem_ready;
        state_nxt = mem_ready ? S0 : S5;
      end
      S6: begin
        ALUSrcA   = 2'b10;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = S7;
      end
      S7: begin
        RegWrite  = 1'b1;
        state_nxt = S0;
      end
      S8: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = S7;
      end
      S9: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        PCUpdate  = 1'b1;
        state_nxt = S7;
      end
      S10: begin
        ALUSrcA   = 2'b10;
        ALUOp     = ALUOP_SUB;
        Branch    = 1'b1;
        state_nxt = S0;
      end
      default: state_nxt = S0;
    endcase
    // The state register already sits in S0 during reset, but S0 strobes
    // follow mem_ready; keep them quiet until reset is released.
    if (!rst_n) begin
      IRWrite  = 1'b0;
      PCUpdate = 1'b0;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Bench for mc_main_fsm: directed instruction scenarios plus randomized
// op/mem_ready traffic, checked against a path-queue model of the controller.
module tb_mc_main_fsm;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       mem_ready;
  logic       PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       illegal_op;
  logic [3:0] state_o;
  logic [13:0] dut_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int exp_state;
  logic exp_ill;
  int path[$];

  // observation records for the directed scenarios
  int hist[$];
  int n_rw, n_mw, n_ill;

  always #5 clk = ~clk;

  mc_main_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCUpdate(PCUpdate), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Branch(Branch), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .state_o(state_o)
  );

  assign dut_ctrl = {PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc,
                     ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Control word required in each state, taken from the state descriptions.
  function automatic logic [13:0] exp_ctrl(input int s, input logic m);
    logic pcu = 0, irw = 0, rw = 0, mw = 0, br = 0, adr = 0;
    logic [1:0] res = 0, a = 0, b = 0, aop = 0;
    case (s)
      0:  begin pcu = m; irw = m; res = 2'b10; b = 2'b10; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1;
      4:  begin res = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = m; end
      6:  begin a = 2'b10; aop = 2'b10; end
      7:  rw = 1;
      8:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      9:  begin a = 2'b01; b = 2'b10; pcu = 1; end
      10: begin a = 2'b10; aop = 2'b01; br = 1; end
      default: ;
    endcase
    return {pcu, irw, rw, mw, br, adr, res, a, b, aop};
  endfunction

  function automatic int pop_or_fetch();
    if (path.size() != 0) return path.pop_front();
    return 0;
  endfunction

  // Advance the model by one clock given the inputs present at the edge.
  task automatic model_advance(input logic [6:0] o, input logic m);
    int nxt;
    logic ill_n;
    ill_n = 1'b0;
    case (exp_state)
      0: nxt = m ? 1 : 0;
      1: begin
        path.delete();
        if (o == OP_LW || o == OP_SW) path.push_back(2);
        else if (o == OP_R)   begin path.push_back(6); path.push_back(7); end
        else if (o == OP_I)   begin path.push_back(8); path.push_back(7); end
        else if (o == OP_JAL) begin path.push_back(9); path.push_back(7); end
        else if (o == OP_BEQ) path.push_back(10);
        else ill_n = 1'b1;
        nxt = pop_or_fetch();
      end
      2: begin
        path.delete();
        if (o == OP_LW) begin path.push_back(3); path.push_back(4); end
        else path.push_back(5);
        nxt = pop_or_fetch();
      end
      3, 5: nxt = m ? pop_or_fetch() : exp_state;
      default: nxt = pop_or_fetch();
    endcase
    exp_state = nxt;
    exp_ill   = ill_n;
  endtask

  task automatic model_reset();
    exp_state = 0;
    exp_ill   = 1'b0;
    path.delete();
  endtask

  // One cycle: drive inputs, check mid-cycle, advance the model after the edge.
  task automatic step(input logic [6:0] o, input logic m);
    op = o;
    mem_ready = m;
    #4;
    chk("state", state_o, exp_state);
    chk("ctrl", dut_ctrl, exp_ctrl(exp_state, m));
    chk("illegal_op", illegal_op, exp_ill);
    hist.push_back(int'(state_o));
    n_rw  += int'(RegWrite);
    n_mw  += int'(MemWrite);
    n_ill += int'(illegal_op);
    @(posedge clk);
    #1;
    model_advance(o, m);
  endtask

  task automatic begin_scn();
    hist.delete();
    n_rw = 0; n_mw = 0; n_ill = 0;
  endtask

  task automatic check_seq(input string tag, input int e[$]);
    chk({tag, "_len"}, hist.size(), e.size());
    for (int i = 0; i < e.size() && i < hist.size(); i++)
      chk(tag, hist[i], e[i]);
  endtask

  initial begin
    int e[$];
    logic [6:0] rop;
    logic rm;
    int sel;

    rst_n = 1'b0;
    op = 7'h00;
    mem_ready = 1'b1;
    model_reset();
    #3;
    chk("rst_state", state_o, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_ctrl", dut_ctrl, exp_ctrl(0, 1'b0));
    mem_ready = 1'b0;
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // R-type
    begin_scn();
    repeat (4) step(OP_R, 1'b1);
    step(OP_R, 1'b0);
    e = '{0, 1, 6, 7, 0};
    check_seq("r_seq", e);
    chk("r_regwrite", n_rw, 1);

    // lw with three wait cycles in MEMREAD
    begin_scn();
    repeat (3) step(OP_LW, 1'b1);
    repeat (3) step(OP_LW, 1'b0);
    step(OP_LW, 1'b1);
    step(OP_LW, 1'b1);
    e = '{0, 1, 2, 3, 3, 3, 3, 4};
    check_seq("lw_seq", e);
    chk("lw_regwrite", n_rw, 1);

    // sw
    begin_scn();
    repeat (4) step(OP_SW, 1'b1);
    step(OP_SW, 1'b0);
    e = '{0, 1, 2, 5, 0};
    check_seq("sw_seq", e);
    chk("sw_memwrite", n_mw, 1);

    // beq
    begin_scn();
    repeat (3) step(OP_BEQ, 1'b1);
    step(OP_BEQ, 1'b0);
    e = '{0, 1, 10, 0};
    check_seq("beq_seq", e);

    // jal
    begin_scn();
    repeat (4) step(OP_JAL, 1'b1);
    step(OP_JAL, 1'b0);
    e = '{0, 1, 9, 7, 0};
    check_seq("jal_seq", e);

    // unsupported opcode
    begin_scn();
    step(7'h7F, 1'b1);
    step(7'h7F, 1'b1);
    step(7'h7F, 1'b0);
    step(7'h7F, 1'b0);
    e = '{0, 1, 0, 0};
    check_seq("ill_seq", e);
    chk("ill_pulses", n_ill, 1);
    chk("ill_regwrite", n_rw, 0);
    chk("ill_memwrite", n_mw, 0);

    // async reset while stalled in MEMWRITE
    repeat (3) step(OP_SW, 1'b1);
    op = OP_SW;
    mem_ready = 1'b0;
    #2;
    chk("pre_rst_state", state_o, 5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", state_o, 0);
    chk("async_rst_memwrite", MemWrite, 0);
    mem_ready = 1'b1;
    #1;
    chk("rst_ctrl_mr1", dut_ctrl, exp_ctrl(0, 1'b0));
    @(posedge clk);
    #3;
    chk("rst_hold_state", state_o, 0);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    begin_scn();
    repeat (4) step(OP_I, 1'b1);
    step(OP_I, 1'b0);
    e = '{0, 1, 8, 7, 0};
    check_seq("post_rst_seq", e);

    // randomized traffic; op may change every cycle
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: rop = OP_LW;
        1: rop = OP_SW;
        2: rop = OP_R;
        3: rop = OP_I;
        4: rop = OP_JAL;
        5: rop = OP_BEQ;
        default: rop = 7'($urandom_range(0, 127));
      endcase
      rm = ($urandom_range(0, 3) != 0);
      step(rop, rm);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_main_fsm.md
MC_MAIN_FSM -- requirements
Module: mc_main_fsm

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  single rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  opcode field of the instruction register
- mem_ready  in  1  memory access completes this cycle
- PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc  out  1 each  datapath strobes and selects
- ResultSrc, ALUSrcA, ALUSrcB, ALUOp  out  2 each  datapath selects; ALUOp feeds alu_dec
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state_o  out  4  current state code, for debug
REQ-002 One clock only (clk); rst_n is asynchronous assert, active-low; no other clock or reset inputs.

Function
REQ-003 The block SHALL be a Moore multicycle controller with 11 states, S0..S10, encoded 4'd0..4'd10; state_o = state register.
REQ-004 Every output field SHALL default to 0 in every state, except as listed in REQ-005..REQ-015.
REQ-005 S0 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=mem_ready; hold in S0 while mem_ready=0; else go to S1.
REQ-006 S1 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state from op:
- 0000011 or 0100011 -> S2
- 0110011 -> S6
- 0010011 -> S8
- 1101111 -> S9
- 1100011 -> S10
- any other op -> S0
REQ-007 S2 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; op=0000011 -> S3, else -> S5.
REQ-008 S3 MEMREAD: AdrSrc=1, ResultSrc=00; hold while mem_ready=0; else -> S4.
REQ-009 S4 MEMWB: ResultSrc=01, RegWrite=1; -> S0.
REQ-010 S5 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=mem_ready; hold while mem_ready=0; else -> S0.
REQ-011 S6 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; -> S7.
REQ-012 S7 ALUWB: ResultSrc=00, RegWrite=1; -> S0.
REQ-013 S8 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; -> S7.
REQ-014 S9 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; -> S7.
REQ-015 S10 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; -> S0. The branch decision (Branch AND zero) is made outside this block.
REQ-016 Unsupported op in S1 SHALL set illegal_op=1 for exactly the following cycle, registered, while the state returns to S0.
REQ-017 Encodings 11..15 SHALL be treated as illegal state codes: outputs all 0, next state S0.
REQ-018 Latencies in cycles, with mem_ready=1 throughout: R/I-type 4, lw 5, sw 4, jal 4, beq 3.
REQ-019 op SHALL be sampled only in S1 and S2; op changes in other states have no effect.

Reset
REQ-020 rst_n=0 SHALL force state=S0 and illegal_op=0 immediately, without waiting for a clock edge.
REQ-021 While rst_n=0, IRWrite, PCUpdate, RegWrite, MemWrite and Branch SHALL be 0; the selects SHALL take their S0 values.
REQ-022 Reset asserted mid-instruction (any state, any mem_ready) SHALL abandon the instruction; the first edge after release starts FETCH.

Structure
REQ-023 Shared package riscv_ctrl_pkg SHALL hold:
- state encodings S0..S10
- opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ
- ALUOp codes 00 add, 01 sub, 10 funct-decoded
REQ-024 No sub-module; the state register, next-state logic and output decode live in mc_main_fsm. alu_dec is instantiated beside it in the controller, not inside it.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, then mem_ready=1, op=0110011 -> states 0,1,6,7,0; RegWrite=1 only in S7; ALUOp=10 in S6.
- op=0000011, mem_ready low for 3 cycles in S3 -> S3 held 4 cycles; RegWrite=1 once, in S4; total 8 cycles.
- op=0100011, mem_ready=1 -> states 0,1,2,5,0; MemWrite=1 for exactly 1 cycle; AdrSrc=1 in S5.
- op=1100011 -> states 0,1,10,0; Branch=1 and ALUOp=01 in S10; op=1101111 -> states 0,1,9,7,0.
- op=1111111 -> states 0,1,0; illegal_op=1 for one cycle; no RegWrite or MemWrite.
- rst_n pulsed low in S5 with mem_ready=0 -> state_o=0 and MemWrite=0 asynchronously; normal fetch after release.
